// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the multi-cycle control sequencer.
// State encoding, opcode map, alu_op codes, the decoded control word and
// opcode-class helper functions.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    localparam logic [3:0] OP_LD  = 4'b0000;
    localparam logic [3:0] OP_ST  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_INV = 4'b0100;
    localparam logic [3:0] OP_LSL = 4'b0101;
    localparam logic [3:0] OP_LSR = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b1000;
    localparam logic [3:0] OP_SLT = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1011;
    localparam logic [3:0] OP_BNE = 4'b1100;
    localparam logic [3:0] OP_JMP = 4'b1101;

    localparam logic [1:0] ALUOP_ADDR  = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // Full set of datapath controls produced for one (state, opcode) pair
    typedef struct packed {
        logic       jump;
        logic       beq;
        logic       bne;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] alu_op;
        logic       pc_write;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_rtype(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_SLT);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return (op == 4'b1010) || (op == 4'b1110) || (op == 4'b1111);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: pure combinational map from (state, latched opcode) to the
// Moore part of the control word. Input-dependent (Mealy) terms in MEM are
// added by the top level.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] op,
    output ctrl_t      ctl
);

    // Moore control word; anything not listed for a state stays 0
    always_comb begin
        ctl = '0;
        case (state)
            ST_DECODE: begin
                if (op == OP_JMP) begin
                    ctl.jump     = 1'b1;
                    ctl.pc_write = 1'b1;
                end else if (is_illegal(op)) begin
                    ctl.illegal_op = 1'b1;
                    ctl.pc_write   = 1'b1;
                end
            end
            ST_EXEC: begin
                if (is_rtype(op)) begin
                    ctl.alu_op = ALUOP_RTYPE;
                end else if (op == OP_LD || op == OP_ST) begin
                    ctl.alu_src = 1'b1;
                    ctl.alu_op  = ALUOP_ADDR;
                end else if (op == OP_BEQ) begin
                    ctl.beq      = 1'b1;
                    ctl.alu_op   = ALUOP_BR;
                    ctl.pc_write = 1'b1;
                end else if (op == OP_BNE) begin
                    ctl.bne      = 1'b1;
                    ctl.alu_op   = ALUOP_BR;
                    ctl.pc_write = 1'b1;
                end
            end
            ST_MEM: begin
                ctl.alu_src   = 1'b1;
                ctl.alu_op    = ALUOP_ADDR;
                ctl.mem_read  = (op == OP_LD);
                ctl.mem_write = (op == OP_ST);
            end
            ST_WB: begin
                ctl.reg_write = 1'b1;
                ctl.pc_write  = 1'b1;
                if (op == OP_LD) begin
                    ctl.mem_to_reg = 1'b1;
                end else if (is_rtype(op)) begin
                    ctl.reg_dst = 1'b1;
                    ctl.alu_op  = ALUOP_RTYPE;
                end
            end
            default: ctl = '0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB controller driving
// the datapath, with a bounded wait for data memory and a sticky timeout flag.
// Optional build macro CTRL_PERF_CNT_EN adds cycle_cnt / instr_cnt outputs.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
`ifdef CTRL_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       opcode,
    input  logic             mem_ready,
    output logic             jump,
    output logic             beq,
    output logic             bne,
    output logic             mem_read,
    output logic             mem_write,
    output logic             alu_src,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic [1:0]       alu_op,
    output logic             pc_write,
    output logic             illegal_op,
    output logic             mem_timeout,
    output logic [2:0]       state_o
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    // Last wait-counter value before the MEM access is abandoned
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] op_q;
    logic [7:0] wait_cnt;
    logic       timeout_now;
    ctrl_t      dec;
    ctrl_t      ctl;

    ctrl_decode u_decode (
        .state (state),
        .op    (op_q),
        .ctl   (dec)
    );

    // A MEM cycle without mem_ready at the last permitted count aborts the access
    assign timeout_now = (state == ST_MEM) && !mem_ready && (wait_cnt == WAIT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_FETCH;
        else        state <= state_next;
    end

    // Next-state logic; unused encodings fall back to FETCH
    always_comb begin
        state_next = ST_FETCH;
        case (state)
            ST_FETCH:  state_next = ST_DECODE;
            ST_DECODE: begin
                if (op_q == OP_JMP || is_illegal(op_q)) state_next = ST_FETCH;
                else                                    state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_rtype(op_q))                      state_next = ST_WB;
                else if (op_q == OP_LD || op_q == OP_ST) state_next = ST_MEM;
                else                                     state_next = ST_FETCH;
            end
            ST_MEM: begin
                if (mem_ready) state_next = (op_q == OP_LD) ? ST_WB : ST_FETCH;
                else if (timeout_now) state_next = ST_FETCH;
                else                  state_next = ST_MEM;
            end
            ST_WB:   state_next = ST_FETCH;
            default: state_next = ST_FETCH;
        endcase
    end

    // Output logic: Moore decode plus the MEM-state store-complete and timeout terms;
    // everything is forced low while reset is asserted so an aborted instruction
    // never updates the PC or a register
    always_comb begin
        ctl = dec;
        if (state == ST_MEM) begin
            if (timeout_now) begin
                ctl.mem_read  = 1'b0;
                ctl.mem_write = 1'b0;
                ctl.pc_write  = 1'b1;
            end else if (mem_ready && op_q == OP_ST) begin
                ctl.pc_write = 1'b1;
            end
        end
        if (!rst_n) ctl = '0;
    end

    assign jump       = ctl.jump;
    assign beq        = ctl.beq;
    assign bne        = ctl.bne;
    assign mem_read   = ctl.mem_read;
    assign mem_write  = ctl.mem_write;
    assign alu_src    = ctl.alu_src;
    assign reg_dst    = ctl.reg_dst;
    assign mem_to_reg = ctl.mem_to_reg;
    assign reg_write  = ctl.reg_write;
    assign alu_op     = ctl.alu_op;
    assign pc_write   = ctl.pc_write;
    assign illegal_op = ctl.illegal_op;
    assign state_o    = state;

    // Opcode latch: captured on leaving FETCH, held for the rest of the instruction
    always_ff @(posedge clk) begin
        if (!rst_n)                 op_q <= 4'd0;
        else if (state == ST_FETCH) op_q <= opcode;
    end

    // Wait counter: zero outside MEM so every MEM entry starts from 0
    always_ff @(posedge clk) begin
        if (!rst_n || state != ST_MEM) wait_cnt <= 8'd0;
        else if (!mem_ready)           wait_cnt <= wait_cnt + 8'd1;
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n)           mem_timeout <= 1'b0;
        else if (timeout_now) mem_timeout <= 1'b1;
    end

`ifdef CTRL_PERF_CNT_EN
    // Performance counters: free-running cycles and retired instructions (one per pc_write)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
            if (ctl.pc_write) instr_cnt <= instr_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed cycle-by-cycle bench for control_sequencer.
// Control word packing used in expectations:
// {jump,beq,bne,mem_read,mem_write,alu_src,reg_dst,mem_to_reg,reg_write,alu_op[1:0],pc_write,illegal_op}
module tb_control_sequencer;

    localparam logic [12:0] C_ZERO     = 13'h0000;
    localparam logic [12:0] C_DEC_JMP  = 13'h1002;
    localparam logic [12:0] C_DEC_ILL  = 13'h0003;
    localparam logic [12:0] C_EX_R     = 13'h0008;
    localparam logic [12:0] C_EX_LS    = 13'h0080;
    localparam logic [12:0] C_EX_BEQ   = 13'h0806;
    localparam logic [12:0] C_EX_BNE   = 13'h0406;
    localparam logic [12:0] C_MEM_LD   = 13'h0280;
    localparam logic [12:0] C_MEM_TO   = 13'h0082;
    localparam logic [12:0] C_MEM_ST   = 13'h0180;
    localparam logic [12:0] C_MEM_STOK = 13'h0182;
    localparam logic [12:0] C_WB_R     = 13'h005A;
    localparam logic [12:0] C_WB_LD    = 13'h0032;

    logic       clk;
    logic       rst_n;
    logic [3:0] opcode;
    logic       mem_ready;
    logic       jump, beq, bne, mem_read, mem_write, alu_src;
    logic       reg_dst, mem_to_reg, reg_write, pc_write, illegal_op, mem_timeout;
    logic [1:0] alu_op;
    logic [2:0] state_o;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
`endif

    int checks = 0;
    int errors = 0;

    control_sequencer #(.MEM_WAIT_MAX(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .jump        (jump),
        .beq         (beq),
        .bne         (bne),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .alu_src     (alu_src),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_op      (alu_op),
        .pc_write    (pc_write),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout),
        .state_o     (state_o)
`ifdef CTRL_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle, check the settled outputs, then advance one clock
    task automatic cyc(input string tag, input logic [3:0] op, input logic rdy,
                       input logic [2:0] exp_state, input logic [12:0] exp_ctl,
                       input logic exp_to);
        logic [12:0] ctl;
        opcode    = op;
        mem_ready = rdy;
        #1;
        ctl = {jump, beq, bne, mem_read, mem_write, alu_src, reg_dst,
               mem_to_reg, reg_write, alu_op, pc_write, illegal_op};
        chk({tag, ".state"}, 32'(state_o), 32'(exp_state));
        chk({tag, ".ctl"}, 32'(ctl), 32'(exp_ctl));
        chk({tag, ".timeout"}, 32'(mem_timeout), 32'(exp_to));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 4'b0010;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset held for 3 cycles with an R-type opcode present
        for (int i = 0; i < 3; i++) cyc("rst", 4'b0010, 1'b0, 3'd0, C_ZERO, 1'b0);
        rst_n = 1'b1;

        // R-type ADD: 0,1,2,4 then back to 0
        cyc("r.f",  4'b0010, 1'b0, 3'd0, C_ZERO, 1'b0);
        cyc("r.d",  4'b0010, 1'b0, 3'd1, C_ZERO, 1'b0);
        cyc("r.e",  4'b0010, 1'b0, 3'd2, C_EX_R, 1'b0);
        cyc("r.wb", 4'b0010, 1'b0, 3'd4, C_WB_R, 1'b0);

        // LD with mem_ready arriving on the 4th MEM cycle: 8 cycles total
        cyc("ld.f",  4'b0000, 1'b0, 3'd0, C_ZERO,   1'b0);
        cyc("ld.d",  4'b0000, 1'b0, 3'd1, C_ZERO,   1'b0);
        cyc("ld.e",  4'b0000, 1'b0, 3'd2, C_EX_LS,  1'b0);
        cyc("ld.m1", 4'b0000, 1'b0, 3'd3, C_MEM_LD, 1'b0);
        cyc("ld.m2", 4'b0000, 1'b0, 3'd3, C_MEM_LD, 1'b0);
        cyc("ld.m3", 4'b0000, 1'b0, 3'd3, C_MEM_LD, 1'b0);
        cyc("ld.m4", 4'b0000, 1'b1, 3'd3, C_MEM_LD, 1'b0);
        cyc("ld.wb", 4'b0000, 1'b0, 3'd4, C_WB_LD,  1'b0);

        // ST with mem_ready high throughout (ignored outside MEM): 4 cycles
        cyc("st.f", 4'b0001, 1'b1, 3'd0, C_ZERO,     1'b0);
        cyc("st.d", 4'b0001, 1'b1, 3'd1, C_ZERO,     1'b0);
        cyc("st.e", 4'b0001, 1'b1, 3'd2, C_EX_LS,    1'b0);
        cyc("st.m", 4'b0001, 1'b1, 3'd3, C_MEM_STOK, 1'b0);

        // BEQ (3 cycles) then JMP (2 cycles)
        cyc("beq.f", 4'b1011, 1'b0, 3'd0, C_ZERO,    1'b0);
        cyc("beq.d", 4'b1011, 1'b0, 3'd1, C_ZERO,    1'b0);
        cyc("beq.e", 4'b1011, 1'b0, 3'd2, C_EX_BEQ,  1'b0);
        cyc("jmp.f", 4'b1101, 1'b0, 3'd0, C_ZERO,    1'b0);
        cyc("jmp.d", 4'b1101, 1'b0, 3'd1, C_DEC_JMP, 1'b0);

        // Illegal 1110, opcode changed to LD after capture
        cyc("ill.f", 4'b1110, 1'b0, 3'd0, C_ZERO,    1'b0);
        cyc("ill.d", 4'b0000, 1'b0, 3'd1, C_DEC_ILL, 1'b0);

        // BNE with opcode changed to LD after capture
        cyc("bne.f", 4'b1100, 1'b0, 3'd0, C_ZERO,   1'b0);
        cyc("bne.d", 4'b0000, 1'b0, 3'd1, C_ZERO,   1'b0);
        cyc("bne.e", 4'b0000, 1'b0, 3'd2, C_EX_BNE, 1'b0);

        // LD that never gets mem_ready: abort on the 15th MEM cycle
        cyc("to.f", 4'b0000, 1'b0, 3'd0, C_ZERO,  1'b0);
        cyc("to.d", 4'b0000, 1'b0, 3'd1, C_ZERO,  1'b0);
        cyc("to.e", 4'b0000, 1'b0, 3'd2, C_EX_LS, 1'b0);
        for (int i = 0; i < 14; i++) cyc("to.mw", 4'b0000, 1'b0, 3'd3, C_MEM_LD, 1'b0);
        cyc("to.m15", 4'b0000, 1'b0, 3'd3, C_MEM_TO, 1'b0);

        // Flag stays set into the next instruction
        cyc("to2.f",  4'b0000, 1'b0, 3'd0, C_ZERO,   1'b1);
        cyc("to2.d",  4'b0000, 1'b0, 3'd1, C_ZERO,   1'b1);
        cyc("to2.e",  4'b0000, 1'b0, 3'd2, C_EX_LS,  1'b1);
        cyc("to2.m1", 4'b0000, 1'b0, 3'd3, C_MEM_LD, 1'b1);
        cyc("to2.m2", 4'b0000, 1'b0, 3'd3, C_MEM_LD, 1'b1);

        // Reset during MEM: outputs drop immediately, FETCH and flag clear next edge
        rst_n = 1'b0;
        cyc("mrst.m", 4'b0000, 1'b0, 3'd3, C_ZERO, 1'b1);
        cyc("mrst.f", 4'b0000, 1'b0, 3'd0, C_ZERO, 1'b0);
        rst_n = 1'b1;

        // ST with two wait cycles after reset: counter starts fresh
        cyc("stw.f",  4'b0001, 1'b0, 3'd0, C_ZERO,     1'b0);
        cyc("stw.d",  4'b0001, 1'b0, 3'd1, C_ZERO,     1'b0);
        cyc("stw.e",  4'b0001, 1'b0, 3'd2, C_EX_LS,    1'b0);
        cyc("stw.m1", 4'b0001, 1'b0, 3'd3, C_MEM_ST,   1'b0);
        cyc("stw.m2", 4'b0001, 1'b0, 3'd3, C_MEM_ST,   1'b0);
        cyc("stw.m3", 4'b0001, 1'b1, 3'd3, C_MEM_STOK, 1'b0);
        cyc("stw.nf", 4'b0001, 1'b0, 3'd0, C_ZERO,     1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
